// File: rtl/mvm_bitserial.sv
// Bit-serial crossbar matrix-vector multiply engine.
// Input bits stream LSB-first; each column accumulates shifted partial sums.
module mvm_bitserial #(
  parameter  int XBAR_SIZE = 8,
  parameter  int IN_BITS   = 8,
  parameter  int WT_BITS   = 8,
  localparam int OUT_BITS  = WT_BITS + IN_BITS + $clog2(XBAR_SIZE),
  localparam int RW        = $clog2(XBAR_SIZE),
  localparam int NW        = $clog2(IN_BITS) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          reset_wt,
  input  logic                          prog_wt,
  input  logic [RW-1:0]                 wt_row,
  input  logic [XBAR_SIZE*WT_BITS-1:0]  wt_data,
  input  logic                          mvm_start,
  input  logic [NW-1:0]                 n,
  input  logic                          signed_in,
  input  logic                          accum,
  input  logic [XBAR_SIZE*IN_BITS-1:0]  xbar_input,
  output logic                          mvm_busy,
  output logic                          mvm_done,
  output logic [XBAR_SIZE*OUT_BITS-1:0] xbar_output
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t state, state_n;

  logic signed [WT_BITS-1:0]  w [XBAR_SIZE][XBAR_SIZE];
  logic signed [OUT_BITS-1:0] acc [XBAR_SIZE];
  logic signed [OUT_BITS-1:0] part [XBAR_SIZE];
  logic signed [OUT_BITS-1:0] acc_n [XBAR_SIZE];

  logic [XBAR_SIZE*IN_BITS-1:0] x_sh;
  logic [NW-1:0] k, n_q, n_eff;
  logic          sgn_q, accum_q, last;

  assign n_eff = (n == '0 || n > NW'(IN_BITS)) ? NW'(IN_BITS) : n;
  assign last  = (k == n_q - NW'(1));

  assign mvm_busy = (state != IDLE);
  assign mvm_done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (mvm_start) state_n = COMPUTE;
      COMPUTE: if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Weights are only writable while idle and survive the async reset.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (reset_wt) begin
        for (int i = 0; i < XBAR_SIZE; i++)
          for (int j = 0; j < XBAR_SIZE; j++)
            w[i][j] <= '0;
      end else if (prog_wt) begin
        for (int j = 0; j < XBAR_SIZE; j++)
          w[wt_row][j] <= wt_data[j*WT_BITS +: WT_BITS];
      end
    end
  end

  // x_sh shifts right each step so bit 0 of each element is the current slice.
  always_comb begin
    for (int j = 0; j < XBAR_SIZE; j++) begin
      part[j] = '0;
      for (int i = 0; i < XBAR_SIZE; i++) begin
        if (x_sh[i*IN_BITS])
          part[j] = part[j] + {{(OUT_BITS-WT_BITS){w[i][j][WT_BITS-1]}}, w[i][j]};
      end
      if (sgn_q && last) acc_n[j] = acc[j] - (part[j] <<< k);
      else               acc_n[j] = acc[j] + (part[j] <<< k);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < XBAR_SIZE; j++) acc[j] <= '0;
      x_sh        <= '0;
      k           <= '0;
      n_q         <= '0;
      sgn_q       <= 1'b0;
      accum_q     <= 1'b0;
      xbar_output <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mvm_start) begin
            for (int j = 0; j < XBAR_SIZE; j++) acc[j] <= '0;
            x_sh    <= xbar_input;
            k       <= '0;
            n_q     <= n_eff;
            sgn_q   <= signed_in;
            accum_q <= accum;
          end
        end
        COMPUTE: begin
          for (int j = 0; j < XBAR_SIZE; j++) acc[j] <= acc_n[j];
          x_sh <= x_sh >> 1;
          k    <= k + NW'(1);
          if (last) begin
            for (int j = 0; j < XBAR_SIZE; j++) begin
              if (accum_q)
                xbar_output[j*OUT_BITS +: OUT_BITS] <=
                  xbar_output[j*OUT_BITS +: OUT_BITS] + acc_n[j];
              else
                xbar_output[j*OUT_BITS +: OUT_BITS] <= acc_n[j];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_bitserial.sv
// Scoreboard bench for mvm_bitserial: directed runs push expected vectors,
// a monitor pops and compares on every mvm_done pulse.
module tb_mvm_bitserial;
  localparam int XB = 8;
  localparam int IB = 8;
  localparam int WB = 8;
  localparam int OB = WB + IB + $clog2(XB);

  logic          clk = 0;
  logic          reset = 1;
  logic          reset_wt = 0;
  logic          prog_wt = 0;
  logic [2:0]    wt_row = 0;
  logic [XB*WB-1:0] wt_data = 0;
  logic          mvm_start = 0;
  logic [3:0]    n = 0;
  logic          signed_in = 0;
  logic          accum = 0;
  logic [XB*IB-1:0] xbar_input = 0;
  logic          mvm_busy, mvm_done;
  logic [XB*OB-1:0] xbar_output;

  int pass_cnt = 0;
  int total = 0;
  logic [XB*OB-1:0] exp_q [$];

  mvm_bitserial #(.XBAR_SIZE(XB), .IN_BITS(IB), .WT_BITS(WB)) dut (
    .clk(clk), .reset(reset), .reset_wt(reset_wt), .prog_wt(prog_wt),
    .wt_row(wt_row), .wt_data(wt_data), .mvm_start(mvm_start), .n(n),
    .signed_in(signed_in), .accum(accum), .xbar_input(xbar_input),
    .mvm_busy(mvm_busy), .mvm_done(mvm_done), .xbar_output(xbar_output)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XB*OB-1:0] act,
                       input logic [XB*OB-1:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (!reset && mvm_done) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        check("result", xbar_output, exp_q.pop_front());
      end
    end
  end

  function automatic logic [XB*OB-1:0] rep(input int v);
    logic [XB*OB-1:0] r;
    for (int j = 0; j < XB; j++) r[j*OB +: OB] = OB'(v);
    return r;
  endfunction

  function automatic logic [XB*IB-1:0] xrep(input logic [IB-1:0] v);
    logic [XB*IB-1:0] r;
    for (int i = 0; i < XB; i++) r[i*IB +: IB] = v;
    return r;
  endfunction

  function automatic logic [XB*WB-1:0] wrep(input logic [WB-1:0] v);
    logic [XB*WB-1:0] r;
    for (int j = 0; j < XB; j++) r[j*WB +: WB] = v;
    return r;
  endfunction

  task automatic prog(input int row, input logic [XB*WB-1:0] d);
    @(negedge clk);
    prog_wt = 1; wt_row = 3'(row); wt_data = d;
    @(posedge clk); #1;
    prog_wt = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (mvm_done) break;
    end
  endtask

  task automatic run(input logic [XB*IB-1:0] x, input int nn, input bit sg,
                     input bit ac, input logic [XB*OB-1:0] e, input int lat);
    int cyc;
    @(negedge clk);
    xbar_input = x; n = 4'(nn); signed_in = sg; accum = ac;
    mvm_start = 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    mvm_start = 0;
    wait_done(cyc);
    check("latency", OB'(cyc), OB'(lat));
    check("busy_at_done", OB'(mvm_busy), OB'(1));
    @(posedge clk); #1;
    check("idle_after", OB'({mvm_busy, mvm_done}), OB'(0));
  endtask

  initial begin
    logic [XB*OB-1:0] e;
    logic [XB*IB-1:0] x;
    int cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", xbar_output, '0);
    check("rst_flags", OB'({mvm_busy, mvm_done}), OB'(0));
    reset = 0;

    for (int r = 0; r < XB; r++) prog(r, wrep(8'd1));

    run(xrep(8'h01), 8, 0, 0, rep(8), 8);
    run(xrep(8'hFF), 8, 0, 0, rep(2040), 8);
    run(xrep(8'hFF), 8, 1, 0, rep(-8), 8);
    run(xrep(8'hFF), 4, 0, 0, rep(120), 4);
    run(xrep(8'hFF), 0, 0, 0, rep(2040), 8);

    // abort at step 3, then confirm weights survived
    @(negedge clk);
    xbar_input = xrep(8'h01); n = 8; signed_in = 0; accum = 0; mvm_start = 1;
    @(posedge clk); #1;
    mvm_start = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    #1;
    check("abort_out", xbar_output, '0);
    check("abort_busy", OB'(mvm_busy), OB'(0));
    repeat (3) @(posedge clk);
    #1 reset = 0;
    run(xrep(8'h01), 8, 0, 0, rep(8), 8);

    // programming and start during COMPUTE are ignored
    @(negedge clk);
    xbar_input = xrep(8'h01); n = 8; mvm_start = 1;
    exp_q.push_back(rep(8));
    @(posedge clk); #1;
    mvm_start = 0;
    @(negedge clk);
    prog_wt = 1; wt_row = 0; wt_data = wrep(8'd5); mvm_start = 1;
    repeat (3) @(posedge clk);
    #1 prog_wt = 0; mvm_start = 0;
    wait_done(cyc);
    repeat (4) @(posedge clk);
    run(xrep(8'h01), 8, 0, 0, rep(8), 8);

    @(negedge clk);
    reset_wt = 1; prog_wt = 1; wt_row = 0; wt_data = wrep(8'd5);
    @(posedge clk); #1;
    reset_wt = 0; prog_wt = 0;
    run(xrep(8'h01), 8, 0, 0, rep(0), 8);

    // identity weights, row by row
    for (int r = 0; r < XB; r++) begin
      logic [XB*WB-1:0] d;
      d = '0;
      d[r*WB +: WB] = 8'd1;
      prog(r, d);
    end
    for (int i = 0; i < XB; i++) begin
      x[i*IB +: IB] = 8'(i);
      e[i*OB +: OB] = OB'(i);
    end
    run(x, 8, 0, 0, e, 8);
    for (int i = 0; i < XB; i++) e[i*OB +: OB] = OB'(i + 1);
    run(xrep(8'h01), 8, 0, 1, e, 8);

    // 3-bit signed inputs with junk in ignored upper bits
    for (int i = 0; i < XB; i++) begin
      x[i*IB +: IB] = 8'hA8 | 8'(i);
      e[i*OB +: OB] = (i < 4) ? OB'(i) : OB'(i - 8);
    end
    run(x, 3, 1, 0, e, 3);

    repeat (3) @(posedge clk);
    check("queue_empty", OB'(exp_q.size()), OB'(0));
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mvm_bitserial.md
Name: mvm_bitserial

Overview:
- Parametrised, bit-serial successor to the crossbar MVM engine.
- Computes xbar_output[j] = sum_i W[i][j] * x[i] over an XBAR_SIZE x XBAR_SIZE weight array.
- Streams input bits LSB-first, one bit-slice per cycle, with shift-and-add accumulation.
- Adds over the previous block: run-time input precision, signed/unsigned inputs, row-wise weight programming, result accumulation across operations, and a busy/done handshake.

Parameters:
- XBAR_SIZE, 8, crossbar rows = columns.
- IN_BITS, 8, maximum input element width.
- WT_BITS, 8, weight width; two's complement.
- OUT_BITS (localparam), WT_BITS+IN_BITS+$clog2(XBAR_SIZE), output element width.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous active-high; clears FSM and outputs (not weights).
- reset_wt, in, 1, synchronous; clears all weights to 0.
- prog_wt, in, 1, write wt_data into row wt_row.
- wt_row, in, $clog2(XBAR_SIZE), row index for prog_wt.
- wt_data, in, XBAR_SIZE*WT_BITS, flattened row; column j is bits [j*WT_BITS +: WT_BITS].
- mvm_start, in, 1, start request; sampled only in IDLE.
- n, in, $clog2(IN_BITS)+1, input precision for this operation.
- signed_in, in, 1, 1 = input bit n-1 is the sign bit.
- accum, in, 1, 1 = add result to current xbar_output.
- xbar_input, in, XBAR_SIZE*IN_BITS, flattened input vector; element i is bits [i*IN_BITS +: IN_BITS].
- mvm_busy, out, 1, operation in progress.
- mvm_done, out, 1, one-cycle completion pulse.
- xbar_output, out, XBAR_SIZE*OUT_BITS, flattened result vector.

Behaviour:
- Reset values: mvm_busy=0, mvm_done=0, xbar_output all 0, FSM=IDLE, internal accumulators 0. Weights are untouched by reset.
- States: IDLE, COMPUTE, DONE.
- IDLE→COMPUTE: on mvm_start=1 at edge T.
  - Latch xbar_input, signed_in and accum.
  - Latch n as n_eff = (n==0 || n>IN_BITS) ? IN_BITS : n.
  - Clear accumulators, set step k=0, set mvm_busy=1.
- COMPUTE, one step per edge (T+1 .. T+n_eff):
  - partial_j = sum over i of bit_k(x_i) ? W[i][j] : 0, computed signed.
  - If signed_in and k==n_eff-1: acc_j -= partial_j<<k; otherwise acc_j += partial_j<<k.
  - After the step with k==n_eff-1, go to DONE.
- Input bits at positions ≥ n_eff are ignored.
- DONE, entered at edge T+n_eff:
  - On that edge, xbar_output_j becomes acc_j, or xbar_output_j + acc_j when accum was latched. Addition wraps modulo 2^OUT_BITS.
  - mvm_done=1 for exactly this one cycle; mvm_busy stays 1 during it.
  - Next edge: IDLE, mvm_done=0, mvm_busy=0.
- Latency: start sampled at T; done visible in cycle T+n_eff+1; outputs valid from then on.
- xbar_output holds its value until the next DONE or reset.
- Back-to-back operation: mvm_start is honoured on the first IDLE cycle after DONE.
- Weight programming, honoured only in IDLE:
  - reset_wt=1 clears every weight at the next edge and takes priority over prog_wt in the same cycle.
  - prog_wt=1 writes W[wt_row][*] = wt_data.
  - prog_wt/reset_wt in the same cycle as mvm_start in IDLE: the weight update completes on that edge, and the computation uses the updated weights.
- While mvm_busy=1: mvm_start, prog_wt and reset_wt are ignored; weights and latched operands are stable.
- Reset mid-operation: asynchronous return to IDLE with outputs at reset values. No mvm_done is produced for the aborted operation. Weights are retained.
- Arithmetic: weights signed; inputs unsigned unless signed_in. OUT_BITS never overflows for a single operation; only accum chaining can wrap.

Test Plan:
1. Weights all 1, inputs all 8'h01, n=8, unsigned, accum=0 → every output 8; mvm_done pulses in cycle T+9; mvm_busy high cycles T+1..T+9.
2. Weights all 1, inputs all 8'hFF, n=8 → unsigned: each output 2040. Signed: each output -8 (19'h7FFF8).
3. Weights all 1, inputs 8'hFF, n=4, unsigned → each output 120, done in cycle T+5. Repeat with n=0 → treated as 8, output 2040, done in T+9.
4. Identity weights programmed row-by-row via prog_wt, inputs 0..7 → output j = j. Then run inputs all 1 with accum=1 → output j = j+1.
5. Issue prog_wt (row 0, all 5) and mvm_start during COMPUTE → both ignored; result unchanged from the original weights; exactly one done pulse. Assert reset_wt and prog_wt together in IDLE → all weights 0; next run outputs 0.
6. Assert reset at step k=3 of case 1 → outputs 0, busy 0, no done pulse. Rerun case 1 without reprogramming → outputs 8, proving weights were retained.
